dispense_arbiter: RTL and testbench

DISPENSE_ARBITER -- requirements
Module: dispense_arbiter

---
 rtl/dispense_arbiter_pkg.sv | 20 ++
 rtl/dispense_arbiter_if.sv | 27 ++
 rtl/dispense_arbiter_rr_arbiter.sv | 27 ++
 rtl/dispense_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dispense_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dispense_arbiter_pkg.sv
// Shared types and constants for the three-product dispense arbiter.
// Holds the FSM state encoding, product-id width/count and round-robin helper.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DELIVER  = 2'd2,
    COOL     = 2'd3
  } state_t;

  localparam int ID_W   = 2;
  localparam int N_PROD = 3;

  // Product ids run 1..3; id 0 (idle) wraps forward to product 1.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id >= 2'd3) ? 2'd1 : id + 2'd1;
  endfunction

endpackage

// File: rtl/dispense_arbiter_if.sv
// Button/dispense bundle between the front panel (master) and the arbiter (slave).
// Requests are level inputs; every output is a registered level or one-cycle pulse.
interface dispense_arbiter_if;

  logic                          req1;
  logic                          req2;
  logic                          req3;
  logic                          product1;
  logic                          product2;
  logic                          product3;
  logic                          delivered;
  logic                          busy;
  logic [vend_pkg::ID_W-1:0]     grant_id;
  logic                          deny;
  logic [vend_pkg::N_PROD-1:0]   empty;

  modport master (
    output req1, req2, req3,
    input  product1, product2, product3, delivered, busy, grant_id, deny, empty
  );

  modport slave (
    input  req1, req2, req3,
    output product1, product2, product3, delivered, busy, grant_id, deny, empty
  );

endinterface

// File: rtl/dispense_arbiter_rr_arbiter.sv
// Combinational 3-way round-robin pick over product ids 1..3.
// Search starts at the product after the last one granted.
module rr_arbiter
  import vend_pkg::*;
(
  input  logic [N_PROD-1:0] pending,
  input  logic [ID_W-1:0]   last,
  output logic              gnt_valid,
  output logic [ID_W-1:0]   gnt_id
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    w_cand    = last;
    for (int i = 0; i < N_PROD; i++) begin
      w_cand = next_id(w_cand);
      if (!gnt_valid && pending[w_cand - 2'd1]) begin
        gnt_valid = 1'b1;
        gnt_id    = w_cand;
      end
    end
  end

endmodule

// File: rtl/dispense_arbiter.sv
// Round-robin vend arbiter driving one shared dispense mechanism for three products.
// Optional per-product stock counting is compiled in with `define STOCK_COUNT_EN.
module dispense_arbiter
  import vend_pkg::*;
#(
  parameter int DISPENSE_CYCLES = 4,
  parameter int COOLDOWN_CYCLES = 2,
  parameter int STOCK_INIT      = 5
) (
  input  logic              clk,
  input  logic              reset,
  dispense_arbiter_if.slave bus,
  output state_t            o_state
);

  localparam logic [7:0] DISP_LOAD = 8'(DISPENSE_CYCLES - 1);
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_CYCLES - 1);
  localparam bit         HAS_COOL  = (COOLDOWN_CYCLES > 0);

  if (DISPENSE_CYCLES < 1 || DISPENSE_CYCLES > 255) begin : g_bad_disp
    $error("DISPENSE_CYCLES out of range 1..255");
  end
  if (COOLDOWN_CYCLES < 0 || COOLDOWN_CYCLES > 255) begin : g_bad_cool
    $error("COOLDOWN_CYCLES out of range 0..255");
  end
  if (STOCK_INIT < 1 || STOCK_INIT > 15) begin : g_bad_stock
    $error("STOCK_INIT out of range 1..15");
  end

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [N_PROD-1:0] r_req_prev;
  logic [N_PROD-1:0] r_pending;
  logic [N_PROD-1:0] r_product;
  logic              r_armed;
  logic              r_delivered;
  logic              r_busy;
  logic              r_deny;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_grant_id;

  logic [N_PROD-1:0] w_req;
  logic [N_PROD-1:0] w_edge;
  logic [N_PROD-1:0] w_empty;
  logic [N_PROD-1:0] w_set;
  logic [N_PROD-1:0] w_drop;
  logic [N_PROD-1:0] w_clr;
  logic [N_PROD-1:0] w_deny_evt;
  logic [N_PROD-1:0] w_gnt_onehot;
  logic              w_gnt_valid;
  logic              w_grant;
  logic [ID_W-1:0]   w_gnt_id;

  // r_armed masks the first cycle after reset so a button held through reset
  // release is absorbed into r_req_prev rather than seen as a press.
  assign w_req        = {bus.req3, bus.req2, bus.req1};
  assign w_edge       = w_req & ~r_req_prev & {N_PROD{r_armed}};
  assign w_set        = w_edge & ~w_empty;
  assign w_drop       = r_pending & w_empty;
  assign w_deny_evt   = (w_edge & w_empty) | w_drop;
  assign w_grant      = (r_state == IDLE) && w_gnt_valid;
  assign w_gnt_onehot = w_gnt_valid ? (3'b001 << (w_gnt_id - 2'd1)) : '0;
  assign w_clr        = w_grant ? w_gnt_onehot : '0;

  rr_arbiter u_rr (
    .pending   (r_pending & ~w_empty),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // A fresh press on the product being granted this cycle re-arms it: set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_prev <= '0;
      r_armed    <= 1'b0;
      r_pending  <= '0;
      r_deny     <= 1'b0;
    end else begin
      r_req_prev <= w_req;
      r_armed    <= 1'b1;
      r_pending  <= (r_pending & ~w_clr & ~w_drop) | w_set;
      r_deny     <= |w_deny_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_product   <= '0;
      r_delivered <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_id  <= '0;
      r_last      <= 2'd3;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state    <= DISPENSE;
            r_cnt      <= DISP_LOAD;
            r_product  <= w_gnt_onehot;
            r_grant_id <= w_gnt_id;
            r_last     <= w_gnt_id;
            r_busy     <= 1'b1;
          end
        end
        DISPENSE: begin
          if (r_cnt == 8'd0) begin
            r_state     <= DELIVER;
            r_cnt       <= '0;
            r_product   <= '0;
            r_delivered <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        DELIVER: begin
          r_delivered <= 1'b0;
          if (HAS_COOL) begin
            r_state <= COOL;
            r_cnt   <= COOL_LOAD;
          end else begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
          end
        end
        COOL: begin
          if (r_cnt == 8'd0) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef STOCK_COUNT_EN
  logic [3:0] r_stock [N_PROD];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_PROD; k++) r_stock[k] <= 4'(STOCK_INIT);
    end else if (r_state == DELIVER) begin
      for (int k = 0; k < N_PROD; k++) begin
        if (r_grant_id == ID_W'(k + 1) && r_stock[k] != 4'd0) r_stock[k] <= r_stock[k] - 4'd1;
      end
    end
  end

  always_comb begin
    w_empty = '0;
    for (int k = 0; k < N_PROD; k++) w_empty[k] = (r_stock[k] == 4'd0);
  end
`else
  assign w_empty = '0;
`endif

  assign bus.product1  = r_product[0];
  assign bus.product2  = r_product[1];
  assign bus.product3  = r_product[2];
  assign bus.delivered = r_delivered;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;
  assign bus.deny      = r_deny;
  assign bus.empty     = w_empty;
  assign o_state       = r_state;

endmodule

// File: tb/tb_dispense_arbiter.sv
// Directed bench for dispense_arbiter: reset, latency, round-robin, set-wins, abort.
// Stock scenario is exercised when STOCK_COUNT_EN is defined.
module tb_dispense_arbiter;
  import vend_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     n_checks;
  int     n_fail;
  logic   seen;

  dispense_arbiter_if bus ();

  dispense_arbiter #(
    .DISPENSE_CYCLES (4),
    .COOLDOWN_CYCLES (2),
    .STOCK_INIT      (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic [2:0] m);
    bus.req1 = m[0];
    bus.req2 = m[1];
    bus.req3 = m[2];
  endtask

  function automatic logic [2:0] prods();
    return {bus.product3, bus.product2, bus.product1};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    check("wait_idle", 8'(bus.busy), 8'd0);
  endtask

  task automatic do_reset();
    set_req(3'b000);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_req(3'b001);
    tick(3);
    // Reset values with req1 held high throughout
    check("rst_prod",   8'(prods()),        8'd0);
    check("rst_deliv",  8'(bus.delivered),  8'd0);
    check("rst_busy",   8'(bus.busy),       8'd0);
    check("rst_gid",    8'(bus.grant_id),   8'd0);
    check("rst_deny",   8'(bus.deny),       8'd0);
    check("rst_empty",  8'(bus.empty),      8'd0);
    check("rst_state",  8'(dbg_state),      8'(IDLE));
    reset = 1'b0;
    tick(4);
    check("held_busy",  8'(bus.busy),       8'd0);
    check("held_prod",  8'(prods()),        8'd0);
    set_req(3'b000);
    tick(2);

    // Single vend of product 2: drive high at t0, observe after each edge
    do_reset();
    set_req(3'b010);
    tick(1);
    set_req(3'b000);
    tick(1);
    check("sv_prod_t2", 8'(prods()),        8'b010);
    check("sv_gid_t2",  8'(bus.grant_id),   8'd2);
    check("sv_busy_t2", 8'(bus.busy),       8'd1);
    tick(3);
    check("sv_prod_t5", 8'(prods()),        8'b010);
    tick(1);
    check("sv_prod_t6", 8'(prods()),        8'd0);
    check("sv_dlv_t6",  8'(bus.delivered),  8'd1);
    check("sv_gid_t6",  8'(bus.grant_id),   8'd2);
    tick(1);
    check("sv_dlv_t7",  8'(bus.delivered),  8'd0);
    tick(1);
    check("sv_busy_t8", 8'(bus.busy),       8'd1);
    tick(1);
    check("sv_busy_t9", 8'(bus.busy),       8'd0);
    check("sv_gid_t9",  8'(bus.grant_id),   8'd0);
    check("sv_deny",    8'(bus.deny),       8'd0);
`ifndef STOCK_COUNT_EN
    check("sv_empty",   8'(bus.empty),      8'd0);
`endif

    // Simultaneous req1 + req3: product1 first, product3 after with no overlap
    do_reset();
    set_req(3'b101);
    tick(1);
    set_req(3'b000);
    tick(1);
    check("sim_p1_t2",  8'(prods()),        8'b001);
    tick(3);
    check("sim_p1_t5",  8'(prods()),        8'b001);
    tick(4);
    check("sim_gap_t9", 8'(prods()),        8'd0);
    tick(1);
    check("sim_p3_t10", 8'(prods()),        8'b100);
    check("sim_gid_t10", 8'(bus.grant_id),  8'd3);
    wait_idle(40);

    // Set-wins: req1 pending behind product2, re-pressed in its own grant cycle
    do_reset();
    set_req(3'b010);
    tick(1);
    set_req(3'b001);
    tick(1);
    set_req(3'b000);
    tick(7);
    check("sw_idle_t9", 8'(bus.busy),       8'd0);
    set_req(3'b001);
    tick(1);
    set_req(3'b000);
    check("sw_p1a",     8'(prods()),        8'b001);
    check("sw_gid_a",   8'(bus.grant_id),   8'd1);
    tick(7);
    check("sw_idle_t17", 8'(bus.busy),      8'd0);
    tick(1);
    check("sw_p1b",     8'(prods()),        8'b001);
    check("sw_gid_b",   8'(bus.grant_id),   8'd1);
    wait_idle(40);
    tick(3);
    check("sw_no_third", 8'(bus.busy),      8'd0);

    // Fairness: all three re-pressed during the first three vends
    do_reset();
    set_req(3'b111);
    tick(1);
    set_req(3'b000);
    begin
      logic [1:0] exp_order [6];
      exp_order = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
      tick(1);
      for (int k = 0; k < 6; k++) begin
        check($sformatf("rr_gid_%0d", k), 8'(bus.grant_id), 8'(exp_order[k]));
        check($sformatf("rr_prod_%0d", k), 8'(prods()), 8'(3'b001 << (exp_order[k] - 2'd1)));
        if (k < 3) begin
          tick(1);
          set_req(3'b111);
          tick(1);
          set_req(3'b000);
          tick(6);
        end else if (k < 5) begin
          tick(8);
        end
      end
    end
    wait_idle(40);

    // Reset during the second DISPENSE cycle aborts the vend
    do_reset();
    set_req(3'b010);
    tick(1);
    set_req(3'b000);
    tick(1);
    check("ab_prod_t2", 8'(prods()),        8'b010);
    tick(1);
    reset = 1'b1;
    tick(1);
    check("ab_prod",    8'(prods()),        8'd0);
    check("ab_busy",    8'(bus.busy),       8'd0);
    check("ab_gid",     8'(bus.grant_id),   8'd0);
    check("ab_dlv",     8'(bus.delivered),  8'd0);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (bus.delivered === 1'b1 || prods() !== 3'b000) seen = 1'b1;
    end
    check("ab_quiet",   8'(seen),           8'd0);
    set_req(3'b100);
    tick(1);
    set_req(3'b000);
    tick(1);
    check("ab_next_p3", 8'(prods()),        8'b100);
    check("ab_next_gid", 8'(bus.grant_id),  8'd3);
    wait_idle(40);

`ifdef STOCK_COUNT_EN
    // Stock of two: third press on product1 is denied
    do_reset();
    set_req(3'b001);
    tick(1);
    set_req(3'b000);
    wait_idle(40);
    check("st_empty_1", 8'(bus.empty),      8'b000);
    set_req(3'b001);
    tick(1);
    set_req(3'b000);
    wait_idle(40);
    check("st_empty_2", 8'(bus.empty),      8'b001);
    set_req(3'b001);
    tick(1);
    set_req(3'b000);
    check("st_deny_t1", 8'(bus.deny),       8'd1);
    tick(1);
    check("st_deny_t2", 8'(bus.deny),       8'd0);
    check("st_prod_t2", 8'(prods()),        8'd0);
    check("st_busy_t2", 8'(bus.busy),       8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
